// File: rtl/inst_sequencer.sv
// inst_sequencer: program sequencer feeding the PE-array instruction decoder.
// A host-written instruction store is replayed on start. Each instruction is
// issued REP+1 times, and stall back-pressure is honoured. After the last
// issue the sequencer waits out the decoder write-back latency, then pulses done.
// Optional feature macro: SEQ_LOOP_EN adds loop_cnt, which replays the whole
// program loop_cnt+1 times per start.
`timescale 1ns/1ps
module inst_sequencer #(
  parameter int INST_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int DRAIN      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [INST_WIDTH-1:0] prog_data,
  input  logic                  start,
  input  logic                  stall,
`ifdef SEQ_LOOP_EN
  input  logic [7:0]            loop_cnt,
`endif
  output logic                  inst_v,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_W-1:0]     pc,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DRAIN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Instruction store: no reset, so it can map onto RAM.
  logic [INST_WIDTH-1:0] store [DEPTH];

  state_t                state_q,  state_d;
  logic [ADDR_W-1:0]     addr_q,   addr_d;
  logic [7:0]            rep_q,    rep_d;
  logic [DRAIN_W-1:0]    drain_q,  drain_d;
  logic                  inst_v_q, inst_v_d;
  logic [INST_WIDTH-1:0] inst_q,   inst_d;
  logic [ADDR_W-1:0]     pc_q,     pc_d;
  logic                  done_q,   done_d;
  logic                  err_q,    err_d;
`ifdef SEQ_LOOP_EN
  logic [7:0]            loop_q,   loop_d;
  logic [7:0]            pass_q,   pass_d;
`endif

  // Fields of the instruction currently addressed by the fetch pointer.
  logic [INST_WIDTH-1:0] cur_inst;
  logic                  cur_last;
  logic [7:0]            cur_rep;
  logic                  pass_end;
  logic                  overflow;

  assign cur_inst = store[addr_q];
  assign cur_last = cur_inst[63];
  assign cur_rep  = cur_inst[47:40];
  // The pass ends at a LAST instruction, or when the top entry runs out.
  assign overflow = !cur_last && (addr_q == LAST_ADDR);
  assign pass_end = cur_last || (addr_q == LAST_ADDR);

  // Host writes land only while idle; a write during a run is dropped.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) begin
      store[prog_addr] <= prog_data;
    end
  end

  // Next-state and registered-output logic for IDLE -> RUN -> DRAIN -> IDLE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rep_d    = rep_q;
    drain_d  = drain_q;
    inst_v_d = 1'b0;
    inst_d   = inst_q;
    pc_d     = pc_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef SEQ_LOOP_EN
    loop_d   = loop_q;
    pass_d   = pass_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
          rep_d   = '0;
`ifdef SEQ_LOOP_EN
          loop_d  = loop_cnt;
          pass_d  = '0;
`endif
        end
      end

      S_RUN: begin
        if (!stall) begin
          inst_v_d = 1'b1;
          inst_d   = cur_inst;
          pc_d     = addr_q;
          if (rep_q == cur_rep) begin
            rep_d = '0;
            err_d = overflow;
            if (pass_end) begin
`ifdef SEQ_LOOP_EN
              if (pass_q != loop_q) begin
                // Another pass follows: rewind with no bubble.
                addr_d = '0;
                pass_d = pass_q + 8'd1;
              end else begin
                state_d = S_DRAIN;
                drain_d = '0;
              end
`else
              state_d = S_DRAIN;
              drain_d = '0;
`endif
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else begin
            rep_d = rep_q + 8'd1;
          end
        end
      end

      S_DRAIN: begin
        // Wait out decoder write-back; stall has no effect here.
        if (drain_q == DRAIN_END) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A host write while a program is in flight is rejected.
    if (prog_we && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
  end

  // State and output registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rep_q    <= '0;
      drain_q  <= '0;
      inst_v_q <= 1'b0;
      inst_q   <= '0;
      pc_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEQ_LOOP_EN
      loop_q   <= '0;
      pass_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rep_q    <= rep_d;
      drain_q  <= drain_d;
      inst_v_q <= inst_v_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef SEQ_LOOP_EN
      loop_q   <= loop_d;
      pass_q   <= pass_d;
`endif
    end
  end

  assign inst_v = inst_v_q;
  assign inst   = inst_q;
  assign pc     = pc_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer.
// The model expands the mirrored store contents into the list of expected
// issues, honouring REP, LAST, the top-of-store limit and loop passes.
// One negedge process compares every inst_v cycle and every done pulse
// against the model. The directed tests pin the latencies, issue counts and
// error counts with hand-computed constants.
`timescale 1ns/1ps
module tb_inst_sequencer;
  localparam int IW    = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DRAIN = 6;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
`ifdef SEQ_LOOP_EN
  logic [7:0]    loop_cnt = 8'd0;
`endif
  logic          inst_v;
  logic [IW-1:0] inst;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          err;

  inst_sequencer #(.INST_WIDTH(IW), .DEPTH(DEPTH), .ADDR_W(AW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stall(stall),
`ifdef SEQ_LOOP_EN
    .loop_cnt(loop_cnt),
`endif
    .inst_v(inst_v), .inst(inst), .pc(pc), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          pc;
    logic [63:0] w;
  } issue_t;

  issue_t      exp_q[$];
  logic [63:0] mem [DEPTH];
  int checks = 0;
  int failures = 0;
  int run_active = 0;
  int issues_in_run = 0;
  int errs_in_run = 0;
  int first_issue_cyc = -1;
  int last_issue_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int issue_total = 0;
  int start_edge = 0;
  int exp_overflow = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk(input logic [2:0] op, input logic [7:0] rep,
                                     input logic last, input logic [15:0] tag);
    logic [63:0] w;
    w = '0;
    w[31:29] = op;
    w[47:40] = rep;
    w[63]    = last;
    w[15:0]  = tag;
    return w;
  endfunction

  // Expand the store into the issue list for the given number of passes.
  task automatic build_expect(input int passes);
    exp_overflow = 0;
    for (int p = 0; p < passes; p++) begin
      bit hit = 0;
      for (int a = 0; a < DEPTH && !hit; a++) begin
        for (int r = 0; r <= int'(mem[a][47:40]); r++) exp_q.push_back('{a, mem[a]});
        if (mem[a][63]) hit = 1;
      end
      if (!hit) exp_overflow++;
    end
  endtask

  // Compare process: every issue against the model, every done against the drain rule.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inst_v) begin
        issue_total++;
        issues_in_run++;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        $display("issue cyc=%0d pc=%0d inst=%h busy=%0b", cyc, pc, inst, busy);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue: got inst_v=1 pc=%0d expected inst_v=0", pc);
        end else begin
          issue_t e;
          e = exp_q.pop_front();
          chk("issue_pc", 64'(pc), 64'(e.pc));
          chk("issue_inst", inst, e.w);
        end
        chk("busy_on_issue", 64'(busy), 64'd1);
      end
      if (err) errs_in_run++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        $display("done cyc=%0d since_last_issue=%0d", cyc, cyc - last_issue_cyc);
        chk("done_in_run", 64'(run_active), 64'd1);
        chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_after_drain", 64'(cyc - last_issue_cyc), 64'(DRAIN));
        chk("busy_at_done", 64'(busy), 64'd0);
        run_active = 0;
      end
    end
  end

  task automatic prog(input logic [AW-1:0] a, input logic [63:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    mem[a] = d;
  endtask

  task automatic run_start(input bit with_write, input logic [AW-1:0] wa, input logic [63:0] wd);
    int passes = 1;
`ifdef SEQ_LOOP_EN
    passes = int'(loop_cnt) + 1;
`endif
    if (with_write) begin
      prog_we = 1'b1;
      prog_addr = wa;
      prog_data = wd;
      mem[wa] = wd;
    end
    build_expect(passes);
    issues_in_run = 0;
    errs_in_run = 0;
    first_issue_cyc = -1;
    run_active = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prog_we = 1'b0;
    start_edge = cyc;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done in %0d cycles expected a done pulse", bound);
    end
  endtask

  task automatic check_run(input string tag, input int lat, input int issues, input int errs);
    chk({tag, "_latency"}, 64'(done_cyc - start_edge), 64'(lat));
    chk({tag, "_issues"}, 64'(issues_in_run), 64'(issues));
    chk({tag, "_errs"}, 64'(errs_in_run), 64'(errs));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_inst_v"}, 64'(inst_v), 64'd0);
    chk({tag, "_inst"}, inst, 64'd0);
    chk({tag, "_pc"}, 64'(pc), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int tot;
    int dc;
    int prev_done;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    // Power-on reset state.
    #12;
    check_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T2 basic run: ADD x1, MUL x3.
    prog(4'd0, mk(OP_ADD, 8'd0, 1'b0, 16'h0011));
    prog(4'd1, mk(OP_MUL, 8'd2, 1'b1, 16'h0022));
    run_start(1'b0, '0, '0);
    chk("t2_model_len", 64'(exp_q.size()), 64'd4);
    chk("t2_model_pc1", 64'(exp_q[1].pc), 64'd1);
    wait_done(100);
    check_run("t2", 10, 4, 0);
    chk("t2_span", 64'(last_issue_cyc - first_issue_cyc), 64'd3);

    // T1 reset mid-run: outputs clear asynchronously, nothing follows.
    run_start(1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("t1_pre_reset_inst_v", 64'(inst_v), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("t1_async");
    exp_q.delete();
    run_active = 0;
    tot = issue_total;
    dc = done_cnt;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t1_post_reset_issues", 64'(issue_total), 64'(tot));
    chk("t1_post_reset_done", 64'(done_cnt), 64'(dc));

    // T3 stall on the 2nd and 3rd issue edges; store[0] written alongside start.
    run_start(1'b1, 4'd0, mk(OP_ADD, 8'd0, 1'b0, 16'h0033));
    @(posedge clk); #1;
    stall = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    stall = 1'b0;
    wait_done(100);
    check_run("t3", 12, 4, 0);
    chk("t3_span", 64'(last_issue_cyc - first_issue_cyc), 64'd5);

    // T4a host write and start while busy: err pulse, store and run unchanged.
    run_start(1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk); #1;
    prog_we = 1'b1;
    prog_addr = 4'd1;
    prog_data = mk(OP_ADD, 8'd5, 1'b0, 16'hDEAD);
    start = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0;
    start = 1'b0;
    wait_done(100);
    check_run("t4a", 10, 4, 1);

    // T4b no LAST anywhere: 16 issues, overflow err, then done.
    for (int a = 0; a < DEPTH; a++) prog(AW'(a), mk(3'(a), 8'd0, 1'b0, 16'(16'h0100 + a)));
    run_start(1'b0, '0, '0);
    chk("t4b_model_overflow", 64'(exp_overflow), 64'd1);
    wait_done(200);
    check_run("t4b", 22, 16, 1);

    // T5 back-to-back: start asserted during the done cycle.
    prog(4'd0, mk(OP_ADD, 8'd0, 1'b0, 16'h0051));
    prog(4'd1, mk(OP_MUL, 8'd2, 1'b1, 16'h0052));
    run_start(1'b0, '0, '0);
    wait_done(100);
    check_run("t5a", 10, 4, 0);
    prev_done = done_cyc;
    chk("t5_in_done_cycle", 64'(done), 64'd1);
    run_start(1'b0, '0, '0);
    wait_done(100);
    check_run("t5b", 10, 4, 0);
    chk("t5_gap", 64'(first_issue_cyc - prev_done), 64'd2);

`ifdef SEQ_LOOP_EN
    // T6 three passes of the two-entry program, contiguous, single done.
    loop_cnt = 8'd2;
    dc = done_cnt;
    run_start(1'b0, '0, '0);
    loop_cnt = 8'd0;
    wait_done(200);
    check_run("t6", 18, 12, 0);
    chk("t6_span", 64'(last_issue_cyc - first_issue_cyc), 64'd11);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_single_done", 64'(done_cnt - dc), 64'd1);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
